// File: rtl/mem_io_pkg.sv
// Shared definitions for the memory/IO bridge: bus command codes, the address map
// and small helpers used by the decode and counter logic.
package mem_io_pkg;

    localparam int          RAM_DEPTH = 256;
    localparam int          ADDR_W    = 9;
    localparam int          DATA_W    = 16;
    localparam logic [8:0]  LED_ADDR  = 9'h100;
    localparam logic [8:0]  SW_ADDR   = 9'h140;

    typedef enum logic [1:0] {
        MNONE    = 2'b00,
        MREAD    = 2'b01,
        MWRITE   = 2'b10,
        MILLEGAL = 2'b11
    } mem_cmd_e;

    // Selects which source drives read_data in the cycle after an MREAD.
    typedef enum logic [1:0] {
        RD_NONE = 2'b00,
        RD_RAM  = 2'b01,
        RD_IO   = 2'b10
    } rd_sel_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mem_io_bridge_if.sv
// CPU-side memory bus: command, address and store data from the CPU, read response back.
interface mem_io_bridge_if
    import mem_io_pkg::*;
();
    logic [ADDR_W-1:0] mem_addr;
    mem_cmd_e          mem_cmd;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    modport master (output mem_addr, output mem_cmd, output write_data, input  read_data);
    modport slave  (input  mem_addr, input  mem_cmd, input  write_data, output read_data);
endinterface

// File: rtl/ram_256x16.sv
// Single-port 256x16 RAM: synchronous write, registered read, contents survive reset.
module ram_256x16
    import mem_io_pkg::*;
(
    input  logic                clk,
    input  logic                we_i,
    input  logic [7:0]          addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o
);

    logic [DATA_W-1:0] mem_q [RAM_DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the array has no reset branch on purpose -- a reset loop over every word
    // would stop this mapping onto block RAM, and the contents must survive reset anyway.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_io_bridge.sv
// CPU memory/IO bridge: RAM, LED register and synchronized switch port behind one bus,
// with 1-cycle read latency, saturating access counters and a sticky bus error flag.
module mem_io_bridge
    import mem_io_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    mem_io_bridge_if.slave    bus,
    input  logic [7:0]        sw,
    input  logic              halt,
    output logic [7:0]        ledr,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
    output logic              bus_err
);

    logic        is_read, is_write, is_ram, is_led, is_sw, is_mapped;
    logic        ram_we;
    logic [15:0] ram_rdata;

    rd_sel_e     rd_sel_d, rd_sel_q;
    logic [7:0]  io_data_d, io_data_q;
    logic [7:0]  ledr_d, ledr_q;
    logic [15:0] rd_count_d, rd_count_q;
    logic [15:0] wr_count_d, wr_count_q;
    logic        bus_err_d, bus_err_q;
    logic [7:0]  sw_meta_q, sw_sync_q;

    ram_256x16 u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (bus.mem_addr[7:0]),
        .wdata_i (bus.write_data),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        is_read   = (bus.mem_cmd == MREAD);
        is_write  = (bus.mem_cmd == MWRITE);
        is_ram    = ~bus.mem_addr[8];
        is_led    = (bus.mem_addr == LED_ADDR);
        is_sw     = (bus.mem_addr == SW_ADDR);
        is_mapped = is_ram | is_led | is_sw;
    end

    // NOTE: every output of this block gets a default before any branch, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        rd_sel_d   = RD_NONE;
        io_data_d  = io_data_q;
        ledr_d     = ledr_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        bus_err_d  = bus_err_q;
        ram_we     = 1'b0;

        if (is_read) begin
            if (is_ram) begin
                rd_sel_d = RD_RAM;
            end else if (is_led) begin
                rd_sel_d  = RD_IO;
                io_data_d = ledr_q;
            end else if (is_sw) begin
                rd_sel_d  = RD_IO;
                io_data_d = sw_sync_q;
            end
        end

        if (is_write) begin
            if (is_ram) begin
                ram_we = 1'b1;
            end else if (is_led) begin
                ledr_d = bus.write_data[7:0];
            end
        end

        if (!halt) begin
            if (is_read)  rd_count_d = sat_inc(rd_count_q);
            if (is_write) wr_count_d = sat_inc(wr_count_q);
        end

        if ((bus.mem_cmd == MILLEGAL) || ((is_read || is_write) && !is_mapped) ||
            (is_write && is_sw)) begin
            bus_err_d = 1'b1;
        end

        // The RAM has no reset of its own, so a write presented during reset is blocked here.
        if (reset) begin
            ram_we = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_sel_q   <= RD_NONE;
            io_data_q  <= 8'h00;
            ledr_q     <= 8'h00;
            rd_count_q <= 16'h0000;
            wr_count_q <= 16'h0000;
            bus_err_q  <= 1'b0;
            sw_meta_q  <= 8'h00;
            sw_sync_q  <= 8'h00;
        end else begin
            rd_sel_q   <= rd_sel_d;
            io_data_q  <= io_data_d;
            ledr_q     <= ledr_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
            bus_err_q  <= bus_err_d;
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
        end
    end

    always_comb begin
        bus.read_data = 16'h0000;
        case (rd_sel_q)
            RD_RAM:  bus.read_data = ram_rdata;
            RD_IO:   bus.read_data = {8'h00, io_data_q};
            default: bus.read_data = 16'h0000;
        endcase
    end

    assign ledr     = ledr_q;
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: a reference model pushes the expected read
// response per cycle into a scoreboard queue, popped and compared after each edge.
module tb_mem_io_bridge;
    import mem_io_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  sw;
    logic        halt;
    logic [7:0]  ledr;
    logic [15:0] rd_count, wr_count;
    logic        bus_err;

    mem_io_bridge_if bus();

    mem_io_bridge dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .sw       (sw),
        .halt     (halt),
        .ledr     (ledr),
        .rd_count (rd_count),
        .wr_count (wr_count),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [15:0] m_ram [256];
    logic [7:0]  m_ledr = 8'h00;
    logic [15:0] m_rd = 16'h0000, m_wr = 16'h0000;
    logic        m_err = 1'b0;
    logic [7:0]  m_s1 = 8'h00, m_s2 = 8'h00;
    logic [15:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drives one bus cycle, predicts its effect, then checks every output after the edge.
    task automatic issue(input mem_cmd_e c, input logic [8:0] a, input logic [15:0] d,
                         input logic rst, input logic h);
        logic [15:0] exp_rd;
        logic [15:0] got;
        reset          = rst;
        halt           = h;
        bus.mem_cmd    = c;
        bus.mem_addr   = a;
        bus.write_data = d;

        exp_rd = 16'h0000;
        if (!rst && c == MREAD) begin
            if (!a[8])               exp_rd = m_ram[a[7:0]];
            else if (a == LED_ADDR)  exp_rd = {8'h00, m_ledr};
            else if (a == SW_ADDR)   exp_rd = {8'h00, m_s2};
        end
        exp_q.push_back(exp_rd);

        @(posedge clk);
        #1;

        if (rst) begin
            m_ledr = 8'h00; m_rd = 16'h0000; m_wr = 16'h0000; m_err = 1'b0;
            m_s1 = 8'h00;   m_s2 = 8'h00;
        end else begin
            if (c == MWRITE && !a[8])      m_ram[a[7:0]] = d;
            if (c == MWRITE && a == LED_ADDR) m_ledr = d[7:0];
            if (!h && c == MREAD  && m_rd != 16'hFFFF) m_rd = m_rd + 16'd1;
            if (!h && c == MWRITE && m_wr != 16'hFFFF) m_wr = m_wr + 16'd1;
            if (c == MILLEGAL) m_err = 1'b1;
            if ((c == MREAD || c == MWRITE) && a[8] && a != LED_ADDR && a != SW_ADDR) m_err = 1'b1;
            if (c == MWRITE && a == SW_ADDR) m_err = 1'b1;
            m_s2 = m_s1;
            m_s1 = sw;
        end

        got = exp_q.pop_front();
        check("read_data", bus.read_data, got);
        check("ledr",      ledr,          m_ledr);
        check("rd_count",  rd_count,      m_rd);
        check("wr_count",  wr_count,      m_wr);
        check("bus_err",   bus_err,       m_err);
    endtask

    initial begin
        reset = 1'b1; halt = 1'b0; sw = 8'h00;
        bus.mem_cmd = MNONE; bus.mem_addr = '0; bus.write_data = '0;

        // Reset state
        issue(MNONE, 9'h000, 16'h0, 1'b1, 1'b0);
        issue(MNONE, 9'h000, 16'h0, 1'b1, 1'b0);
        check("reset_read_data", bus.read_data, 16'h0000);
        check("reset_bus_err",   bus_err,       1'b0);

        // Write then immediate read of the same RAM word
        issue(MWRITE, 9'h005, 16'hBEEF, 1'b0, 1'b0);
        issue(MREAD,  9'h005, 16'h0,    1'b0, 1'b0);
        check("ram_beef", bus.read_data, 16'hBEEF);
        check("ram_wr1",  wr_count, 16'd1);
        check("ram_rd1",  rd_count, 16'd1);
        issue(MNONE, 9'h005, 16'h0, 1'b0, 1'b0);
        check("idle_zero", bus.read_data, 16'h0000);

        // LED register write and readback
        issue(MWRITE, LED_ADDR, 16'h12A5, 1'b0, 1'b0);
        check("led_a5", ledr, 8'hA5);
        issue(MREAD,  LED_ADDR, 16'h0,    1'b0, 1'b0);
        check("led_read", bus.read_data, 16'h00A5);

        // Switch port through the synchronizer, then an illegal write to it
        sw = 8'h3C;
        repeat (3) issue(MNONE, 9'h000, 16'h0, 1'b0, 1'b0);
        issue(MREAD, SW_ADDR, 16'h0, 1'b0, 1'b0);
        check("sw_read", bus.read_data, 16'h003C);
        issue(MWRITE, SW_ADDR, 16'h00FF, 1'b0, 1'b0);
        check("sw_wr_err",  bus_err, 1'b1);
        check("sw_wr_ledr", ledr, 8'hA5);

        // Unmapped read, illegal command, stickiness of bus_err
        issue(MNONE, 9'h000, 16'h0, 1'b1, 1'b0);
        issue(MREAD, 9'h1FF, 16'h0, 1'b0, 1'b0);
        check("unmapped_rd", bus.read_data, 16'h0000);
        check("unmapped_err", bus_err, 1'b1);
        issue(MILLEGAL, 9'h005, 16'h1234, 1'b0, 1'b0);
        check("illegal_rd_cnt", rd_count, 16'd1);
        check("illegal_wr_cnt", wr_count, 16'd0);
        repeat (5) issue(MNONE, 9'h000, 16'h0, 1'b0, 1'b0);
        check("err_sticky", bus_err, 1'b1);
        issue(MNONE, 9'h000, 16'h0, 1'b1, 1'b0);
        check("err_cleared", bus_err, 1'b0);

        // Reset priority: write during reset is dropped, pending read is discarded
        issue(MWRITE, 9'h010, 16'h5A5A, 1'b0, 1'b0);
        issue(MWRITE, LED_ADDR, 16'h0077, 1'b0, 1'b0);
        issue(MREAD,  9'h005, 16'h0, 1'b0, 1'b0);
        issue(MWRITE, 9'h010, 16'h0001, 1'b1, 1'b0);
        check("rst_read_data", bus.read_data, 16'h0000);
        check("rst_ledr",      ledr, 8'h00);
        check("rst_wr_count",  wr_count, 16'h0000);
        issue(MREAD, 9'h010, 16'h0, 1'b0, 1'b0);
        check("rst_ram_kept", bus.read_data, 16'h5A5A);

        // Mixed random traffic against the model
        for (int i = 0; i < 16; i++) issue(MWRITE, 9'(i), 16'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            logic [8:0] a;
            case ($urandom_range(0, 5))
                0, 1, 2: a = 9'($urandom_range(0, 15));
                3:       a = LED_ADDR;
                4:       a = SW_ADDR;
                default: a = 9'h1A0;
            endcase
            if ($urandom_range(0, 9) == 0) sw = 8'($urandom);
            issue(mem_cmd_e'($urandom_range(0, 3)), a, 16'($urandom), 1'b0,
                  ($urandom_range(0, 3) == 0));
        end

        // Counter saturation and halt freeze
        issue(MNONE, 9'h000, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 65534; i++) issue(MREAD, 9'h005, 16'h0, 1'b0, 1'b0);
        check("rd_fffe", rd_count, 16'hFFFE);
        repeat (3) issue(MREAD, 9'h005, 16'h0, 1'b0, 1'b0);
        check("rd_sat", rd_count, 16'hFFFF);
        issue(MWRITE, 9'h020, 16'hC0DE, 1'b0, 1'b1);
        check("halt_wr_cnt", wr_count, 16'h0000);
        repeat (3) issue(MREAD, 9'h020, 16'h0, 1'b0, 1'b1);
        check("halt_rd_cnt", rd_count, 16'hFFFF);
        check("halt_ram_rd", bus.read_data, 16'hC0DE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_io_bridge.md
MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 SHALL provide clk  input  1  system clock; all state updates on the rising edge.
REQ-002 SHALL provide reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL provide mem_addr  input  9  word address from the CPU.
REQ-004 SHALL provide mem_cmd  input  2  bus command: 00 NONE, 01 MREAD, 10 MWRITE, 11 illegal.
REQ-005 SHALL provide write_data  input  16  CPU store data, sampled on an MWRITE cycle.
REQ-006 SHALL provide read_data  output  16  read response to the CPU (the CPU's in port).
REQ-007 SHALL provide sw  input  8  asynchronous slide switches.
REQ-008 SHALL provide halt  input  1  CPU halt indication.
REQ-009 SHALL provide ledr  output  8  registered LED port.
REQ-010 SHALL provide rd_count  output  16  count of MREAD cycles.
REQ-011 SHALL provide wr_count  output  16  count of MWRITE cycles.
REQ-012 SHALL provide bus_err  output  1  sticky bus error flag.

Function
REQ-013 SHALL decode addresses as follows: 0x000-0x0FF RAM (mem_addr[8]=0); 0x100 LED register (read/write); 0x140 switch port (read-only); all other addresses unmapped.
REQ-014 SHALL write write_data into RAM[mem_addr[7:0]] at the clock edge ending an MWRITE cycle to RAM.
REQ-015 SHALL load ledr with write_data[7:0] at the edge ending an MWRITE cycle to 0x100.
REQ-016 SHALL return read data with a latency of exactly 1 cycle: read_data reflects the MREAD issued in cycle N during cycle N+1 and holds it until the next edge.
REQ-017 SHALL return read data per target: RAM word for RAM reads; {8'h00, ledr} for 0x100, using the ledr value at the request edge; {8'h00, sw_sync} for 0x140.
REQ-018 SHALL drive read_data 16'h0000 in any cycle that does not follow a valid MREAD, i.e. after NONE, MWRITE, illegal or unmapped commands.
REQ-019 SHALL pass sw through a 2-flop synchronizer (sw_sync); a switch change becomes readable no earlier than 2 edges later.
REQ-020 SHALL increment rd_count once per cycle with mem_cmd=MREAD, regardless of address, and wr_count once per cycle with mem_cmd=MWRITE.
REQ-021 SHALL saturate both counters at 16'hFFFF, with no wrap.
REQ-022 SHALL freeze both counters while halt=1; RAM, LED and read paths SHALL remain functional.
REQ-023 SHALL set bus_err on any of: mem_cmd=11; MREAD or MWRITE to an unmapped address; MWRITE to 0x140 (write ignored, no state change). bus_err SHALL stay set until reset.
REQ-024 SHALL count erroneous MREAD/MWRITE cycles in rd_count/wr_count; mem_cmd=11 SHALL change neither counter.
REQ-025 SHALL treat back-to-back MREADs as fully pipelined, one response per cycle; an MWRITE immediately followed by an MREAD to the same address SHALL return the new data.

Reset
REQ-026 SHALL clear, on reset: read_data=0, ledr=0, rd_count=0, wr_count=0, bus_err=0, synchronizer flops=0, and the read-valid pipeline flag.
REQ-027 SHALL preserve RAM contents across reset.
REQ-028 SHALL give reset priority over any simultaneous command; a command presented in a reset cycle SHALL have no effect, including no RAM write.
REQ-029 SHALL discard an MREAD issued in the cycle before reset asserts; read_data SHALL be 0 after the reset edge.

Structure
REQ-030 SHALL place in shared package mem_io_pkg: the command codes (MNONE, MREAD, MWRITE), the address constants (LED_ADDR=9'h100, SW_ADDR=9'h140) and RAM_DEPTH=256.
REQ-031 SHALL implement storage in one sub-module, ram_256x16: single port, synchronous write, registered read, no reset.
REQ-032 SHALL implement the decode, counter, error and synchronizer logic in mem_io_bridge itself.

Verification
REQ-033 SHALL cover: MWRITE 0x005 data 16'hBEEF, then MREAD 0x005 -> read_data=16'hBEEF in the following cycle; wr_count=1, rd_count=1.
REQ-034 SHALL cover: MWRITE 0x100 data 16'h12A5 -> ledr=8'hA5 next cycle; then MREAD 0x100 -> read_data=16'h00A5.
REQ-035 SHALL cover: sw=8'h3C held, 3 cycles later MREAD 0x140 -> read_data=16'h003C; then MWRITE 0x140 -> bus_err=1, ledr unchanged.
REQ-036 SHALL cover: MREAD 0x1FF -> read_data=0, bus_err=1; mem_cmd=11 for 1 cycle -> counters unchanged; bus_err cleared only by reset.
REQ-037 SHALL cover: preload rd_count to 16'hFFFE via 2^16-2 reads, then 3 MREADs -> rd_count=16'hFFFF; with halt=1, further MREADs leave it unchanged.
REQ-038 SHALL cover: MWRITE 0x010 data 16'h0001 with reset asserted -> after reset, MREAD 0x010 returns the prior contents, not 16'h0001; all outputs 0 after the reset edge.
